// File: rtl/life_pkg.sv
// Shared types and constants for the 16x16 toroidal Life run controller.
package life_pkg;

   localparam int unsigned BOARD_W = 256;
   localparam int unsigned ROW_W   = 16;
   localparam int unsigned POP_W   = 9;

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_RUN  = 2'd1,
      OP_STEP = 2'd2,
      OP_STOP = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      CAUSE_LIMIT   = 2'd0,
      CAUSE_EXTINCT = 2'd1,
      CAUSE_STILL   = 2'd2,
      CAUSE_STOPPED = 2'd3
   } done_cause_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD     = 2'd1,
      ST_STEP_PH  = 2'd2,
      ST_CHECK_PH = 2'd3
   } state_e;

endpackage

// File: rtl/life_popcount.sv
// Combinational population count of a 256-cell board: per-row counts, then a pairwise adder tree.
module life_popcount
   import life_pkg::*;
(
   input  logic [BOARD_W-1:0] board_i,
   output logic [POP_W-1:0]   count_o
);

   localparam int unsigned ROW_CNT_W = 5;

   logic [ROW_CNT_W-1:0] row_cnt [ROW_W];
   logic [5:0]           sum1    [8];
   logic [6:0]           sum2    [4];
   logic [7:0]           sum3    [2];

   always_comb begin
      for (int r = 0; r < 16; r++) begin
         row_cnt[r] = '0;
         for (int c = 0; c < 16; c++) begin
            row_cnt[r] = row_cnt[r] + ROW_CNT_W'(board_i[r*16 + c]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         sum1[i] = 6'(row_cnt[2*i]) + 6'(row_cnt[2*i + 1]);
      end
      for (int i = 0; i < 4; i++) begin
         sum2[i] = 7'(sum1[2*i]) + 7'(sum1[2*i + 1]);
      end
      for (int i = 0; i < 2; i++) begin
         sum3[i] = 8'(sum2[2*i]) + 8'(sum2[2*i + 1]);
      end
   end

   assign count_o = POP_W'(sum3[0]) + POP_W'(sum3[1]);

endmodule

// File: rtl/life_run_ctrl.sv
// Command sequencer for the step-enabled Life engine: load, run-N, step, stop, auto-halt.
// Optional period-2 oscillator detection (adds prev2 register and osc port) under LIFE_PERIOD2_DETECT_EN.
module life_run_ctrl
   import life_pkg::*;
#(
   parameter int unsigned GEN_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [BOARD_W-1:0] cmd_board,
   input  logic [GEN_W-1:0]   cmd_gens,
   output logic               eng_load,
   output logic [BOARD_W-1:0] eng_data,
   output logic               eng_step,
   input  logic [BOARD_W-1:0] eng_q,
   output logic               busy,
   output logic               done,
   output logic [1:0]         done_cause,
   output logic [GEN_W-1:0]   gen_count,
`ifdef LIFE_PERIOD2_DETECT_EN
   output logic               osc,
`endif
   output logic [POP_W-1:0]   pop_count
);

   state_e               state_q, state_d;
   logic [GEN_W-1:0]     remaining_q, remaining_d;
   logic                 unlimited_q, unlimited_d;
   logic [BOARD_W-1:0]   prev_board_q, prev_board_d;
   logic [GEN_W-1:0]     gen_count_q, gen_count_d;
   logic [BOARD_W-1:0]   eng_data_q, eng_data_d;
   logic                 done_q, done_d;
   done_cause_e          done_cause_q, done_cause_d;
`ifdef LIFE_PERIOD2_DETECT_EN
   logic [BOARD_W-1:0]   prev2_board_q, prev2_board_d;
   logic                 osc_q, osc_d;
   logic                 fin_osc_c;
`endif

   cmd_op_e     op_c;
   logic        stop_c;
   logic        fin_c;
   done_cause_e fin_cause_c;

   assign op_c   = cmd_op_e'(cmd_op);
   assign stop_c = cmd_valid && (op_c == OP_STOP);

   // Next-state and register updates; a finishing run is collected in fin_c and applied once.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      unlimited_d  = unlimited_q;
      prev_board_d = prev_board_q;
      gen_count_d  = gen_count_q;
      eng_data_d   = eng_data_q;
      done_d       = 1'b0;
      done_cause_d = done_cause_q;
      fin_c        = 1'b0;
      fin_cause_c  = CAUSE_LIMIT;
`ifdef LIFE_PERIOD2_DETECT_EN
      prev2_board_d = prev2_board_q;
      osc_d         = osc_q;
      fin_osc_c     = 1'b0;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (op_c)
                  OP_LOAD: begin
                     eng_data_d  = cmd_board;
                     gen_count_d = '0;
                     state_d     = ST_LOAD;
                  end
                  OP_RUN: begin
                     remaining_d = cmd_gens;
                     unlimited_d = (cmd_gens == '0);
                     state_d     = ST_STEP_PH;
                  end
                  OP_STEP: begin
                     remaining_d = GEN_W'(1);
                     unlimited_d = 1'b0;
                     state_d     = ST_STEP_PH;
                  end
                  default: ;
               endcase
            end
         end

         ST_LOAD: state_d = ST_IDLE;

         ST_STEP_PH: begin
            prev_board_d = eng_q;
`ifdef LIFE_PERIOD2_DETECT_EN
            prev2_board_d = prev_board_q;
`endif
            gen_count_d = (&gen_count_q) ? gen_count_q : gen_count_q + GEN_W'(1);
            if (!unlimited_q) begin
               remaining_d = remaining_q - GEN_W'(1);
            end
            // The step issued this cycle always lands; a STOP only skips the check.
            if (stop_c) begin
               fin_c       = 1'b1;
               fin_cause_c = CAUSE_STOPPED;
            end else begin
               state_d = ST_CHECK_PH;
            end
         end

         ST_CHECK_PH: begin
            if (stop_c) begin
               fin_c       = 1'b1;
               fin_cause_c = CAUSE_STOPPED;
            end else if (eng_q == '0) begin
               fin_c       = 1'b1;
               fin_cause_c = CAUSE_EXTINCT;
            end else if (eng_q == prev_board_q) begin
               fin_c       = 1'b1;
               fin_cause_c = CAUSE_STILL;
`ifdef LIFE_PERIOD2_DETECT_EN
            end else if ((eng_q == prev2_board_q) && (gen_count_q >= GEN_W'(2))) begin
               fin_c       = 1'b1;
               fin_cause_c = CAUSE_STOPPED;
               fin_osc_c   = 1'b1;
`endif
            end else if ((remaining_q == '0) && !unlimited_q) begin
               fin_c       = 1'b1;
               fin_cause_c = CAUSE_LIMIT;
            end else begin
               state_d = ST_STEP_PH;
            end
         end
      endcase

      if (fin_c) begin
         done_d       = 1'b1;
         done_cause_d = fin_cause_c;
         state_d      = ST_IDLE;
`ifdef LIFE_PERIOD2_DETECT_EN
         osc_d        = fin_osc_c;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         remaining_q   <= '0;
         unlimited_q   <= 1'b0;
         prev_board_q  <= '0;
         gen_count_q   <= '0;
         eng_data_q    <= '0;
         done_q        <= 1'b0;
         done_cause_q  <= CAUSE_LIMIT;
`ifdef LIFE_PERIOD2_DETECT_EN
         prev2_board_q <= '0;
         osc_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         unlimited_q   <= unlimited_d;
         prev_board_q  <= prev_board_d;
         gen_count_q   <= gen_count_d;
         eng_data_q    <= eng_data_d;
         done_q        <= done_d;
         done_cause_q  <= done_cause_d;
`ifdef LIFE_PERIOD2_DETECT_EN
         prev2_board_q <= prev2_board_d;
         osc_q         <= osc_d;
`endif
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE) || (op_c == OP_STOP);
   assign eng_load   = (state_q == ST_LOAD);
   assign eng_step   = (state_q == ST_STEP_PH);
   assign eng_data   = eng_data_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign done_cause = done_cause_q;
   assign gen_count  = gen_count_q;
`ifdef LIFE_PERIOD2_DETECT_EN
   assign osc        = osc_q;
`endif

   life_popcount u_popcount (
      .board_i (eng_q),
      .count_o (pop_count)
   );

endmodule

// File: tb/tb_life_run_ctrl.sv
// Bench for life_run_ctrl: behavioural Life engine plus a generation-level reference model.
module tb_life_run_ctrl;
   import life_pkg::*;

   localparam int unsigned GEN_W = 16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [1:0]         cmd_op = 2'd0;
   logic [255:0]       cmd_board = '0;
   logic [GEN_W-1:0]   cmd_gens = '0;
   logic               eng_load;
   logic [255:0]       eng_data;
   logic               eng_step;
   logic [255:0]       eng_q = '0;
   logic               busy;
   logic               done;
   logic [1:0]         done_cause;
   logic [GEN_W-1:0]   gen_count;
   logic [8:0]         pop_count;
`ifdef LIFE_PERIOD2_DETECT_EN
   logic               osc;
`endif

   int checks = 0;
   int failures = 0;
   int excl_viol = 0;

   life_run_ctrl #(.GEN_W(GEN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_board  (cmd_board),
      .cmd_gens   (cmd_gens),
      .eng_load   (eng_load),
      .eng_data   (eng_data),
      .eng_step   (eng_step),
      .eng_q      (eng_q),
      .busy       (busy),
      .done       (done),
      .done_cause (done_cause),
      .gen_count  (gen_count),
`ifdef LIFE_PERIOD2_DETECT_EN
      .osc        (osc),
`endif
      .pop_count  (pop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] life_next(input logic [255:0] b);
      logic [255:0] n;
      int cnt;
      n = '0;
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) begin
                     cnt += int'(b[16*((r + dr + 16) % 16) + ((c + dc + 16) % 16)]);
                  end
               end
            end
            n[16*r + c] = (cnt == 3) || (cnt == 2 && b[16*r + c]);
         end
      end
      return n;
   endfunction

   // Engine: loads or advances one generation on the clock edge; untouched by controller reset.
   always @(posedge clk) begin
      if (eng_load) eng_q <= eng_data;
      else if (eng_step) eng_q <= life_next(eng_q);
   end

   always @(negedge clk) begin
      if (eng_load && eng_step) excl_viol++;
   end

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: generation by generation from the start board; a STOP at cycle s lands in
   // generation (s+1)/2's step (odd s) or check (even s) and preempts any other outcome.
   function automatic void model_run(input logic [255:0] start, input int limit, input int stop_cyc,
                                     output int gens, output int cause, output bit oscf,
                                     output int lat, output logic [255:0] fin);
      logic [255:0] cur, pp, nb;
      int g;
      bit ended;
      cur = start; pp = '0; g = 0; ended = 0;
      cause = 0; oscf = 0; lat = 0;
      while (!ended && g < 4000) begin
         g++;
         nb = life_next(cur);
         if (stop_cyc == 2*g - 1 || stop_cyc == 2*g) begin
            cause = 3; lat = stop_cyc; ended = 1;
         end else if (nb == '0) begin
            cause = 1; lat = 2*g; ended = 1;
         end else if (nb == cur) begin
            cause = 2; lat = 2*g; ended = 1;
`ifdef LIFE_PERIOD2_DETECT_EN
         end else if (g >= 2 && nb == pp) begin
            cause = 3; oscf = 1; lat = 2*g; ended = 1;
`endif
         end else if (limit != 0 && g == limit) begin
            cause = 0; lat = 2*g; ended = 1;
         end
         pp = cur;
         cur = nb;
      end
      gens = g;
      fin = cur;
   endfunction

   task automatic do_load(input logic [255:0] b, input string tag);
      cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_board = b;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, "_load_board"}, eng_q, b);
      check_eq({tag, "_load_gen0"}, 256'(gen_count), 256'd0);
   endtask

   task automatic do_scenario(input logic [255:0] b, input logic [1:0] op, input int gens,
                              input int stop_cyc, input string tag,
                              output int o_lat, output int o_cause, output int o_gens);
      int e_gens, e_cause, e_lat, n, steps, limit;
      bit e_osc, seen;
      logic [255:0] e_fin;
      limit = (op == OP_STEP) ? 1 : gens;
      model_run(b, limit, stop_cyc, e_gens, e_cause, e_osc, e_lat, e_fin);
      do_load(b, tag);
      cmd_valid = 1'b1; cmd_op = op; cmd_gens = GEN_W'(gens);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (stop_cyc == 1) begin cmd_valid = 1'b1; cmd_op = OP_STOP; end
      seen = 0; n = 0;
      while (!seen && n < e_lat + 8) begin
         @(posedge clk); #1;
         n++;
         if (n == stop_cyc) cmd_valid = 1'b0;
         if (done) seen = 1;
         else if (stop_cyc != 0 && n == stop_cyc - 1) begin cmd_valid = 1'b1; cmd_op = OP_STOP; end
      end
      cmd_valid = 1'b0;
      check_eq({tag, "_done_seen"}, 256'(seen), 256'd1);
      check_eq({tag, "_latency"}, 256'(n), 256'(e_lat));
      check_eq({tag, "_cause"}, 256'(done_cause), 256'(e_cause));
      check_eq({tag, "_gen_count"}, 256'(gen_count), 256'(e_gens));
      check_eq({tag, "_board"}, eng_q, e_fin);
      check_eq({tag, "_pop"}, 256'(pop_count), 256'($countones(eng_q)));
      check_eq({tag, "_busy_at_done"}, 256'(busy), 256'd0);
`ifdef LIFE_PERIOD2_DETECT_EN
      check_eq({tag, "_osc"}, 256'(osc), 256'(e_osc));
`endif
      o_lat = n; o_cause = int'(done_cause); o_gens = int'(gen_count);
      steps = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (eng_step) steps++;
         if (i == 0) check_eq({tag, "_done_pulse"}, 256'(done), 256'd0);
      end
      check_eq({tag, "_no_step_after"}, 256'(steps), 256'd0);
   endtask

   initial begin
      logic [255:0] blinker, block, single, glider, rb;
      int lat, cause, gc, g, sc, e_gens, e_cause, e_lat;
      bit e_osc;
      logic [255:0] e_fin;
      logic [1:0] op;

      blinker = '0; blinker[84] = 1'b1; blinker[85] = 1'b1; blinker[86] = 1'b1;
      block = '0; block[0] = 1'b1; block[1] = 1'b1; block[16] = 1'b1; block[17] = 1'b1;
      single = '0; single[0] = 1'b1;
      glider = '0; glider[1] = 1'b1; glider[18] = 1'b1;
      glider[32] = 1'b1; glider[33] = 1'b1; glider[34] = 1'b1;

      #1;
      check_eq("rst_busy", 256'(busy), 256'd0);
      check_eq("rst_done", 256'(done), 256'd0);
      check_eq("rst_cause", 256'(done_cause), 256'd0);
      check_eq("rst_gen", 256'(gen_count), 256'd0);
      check_eq("rst_eng_data", eng_data, 256'd0);
      check_eq("rst_eng_ctl", 256'({eng_load, eng_step}), 256'd0);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // STOP while idle is accepted but does nothing.
      cmd_valid = 1'b1; cmd_op = OP_STOP;
      check_eq("idle_stop_ready", 256'(cmd_ready), 256'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check_eq("idle_stop_quiet", 256'({busy, done}), 256'd0);

      do_scenario(blinker, OP_RUN, 10, 0, "blinker", lat, cause, gc);
`ifdef LIFE_PERIOD2_DETECT_EN
      check_eq("blinker_plan_lat", 256'(lat), 256'd4);
      check_eq("blinker_plan_cause", 256'(cause), 256'd3);
      check_eq("blinker_plan_osc", 256'(osc), 256'd1);
`else
      check_eq("blinker_plan_lat", 256'(lat), 256'd20);
      check_eq("blinker_plan_cause", 256'(cause), 256'd0);
      check_eq("blinker_plan_gen", 256'(gc), 256'd10);
`endif

      do_scenario(block, OP_RUN, 0, 0, "block", lat, cause, gc);
      check_eq("block_plan_cause", 256'(cause), 256'd2);
      check_eq("block_plan_gen", 256'(gc), 256'd1);
      check_eq("block_plan_pop", 256'(pop_count), 256'd4);

      do_scenario(single, OP_STEP, 0, 0, "single", lat, cause, gc);
      check_eq("single_plan_cause", 256'(cause), 256'd1);
      check_eq("single_plan_gen", 256'(gc), 256'd1);
      check_eq("single_plan_board", eng_q, 256'd0);

      do_scenario(glider, OP_RUN, 0, 5, "glider_stop", lat, cause, gc);
      check_eq("glider_stop_plan_cause", 256'(cause), 256'd3);
      check_eq("glider_stop_plan_gen", 256'(gc), 256'd3);

      do_scenario(glider, OP_RUN, 64, 0, "glider64", lat, cause, gc);
      check_eq("glider64_plan_cause", 256'(cause), 256'd0);
      check_eq("glider64_plan_wrap", eng_q, glider);
      check_eq("glider64_plan_gen", 256'(gc), 256'd64);

      for (int it = 0; it < 20; it++) begin
         rb = '0;
         for (int w = 0; w < 8; w++) rb[32*w +: 32] = $urandom() & $urandom();
         if ($urandom_range(0, 3) == 0) begin op = OP_STEP; g = 0; end
         else begin op = OP_RUN; g = $urandom_range(1, 12); end
         model_run(rb, (op == OP_STEP) ? 1 : g, 0, e_gens, e_cause, e_osc, e_lat, e_fin);
         sc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, e_lat) : 0;
         do_scenario(rb, op, g, sc, $sformatf("rand%0d", it), lat, cause, gc);
      end

      // Asynchronous reset in the middle of an unlimited run.
      do_load(glider, "rst_mid");
      cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_gens = '0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_mid_busy", 256'(busy), 256'd0);
      check_eq("rst_mid_gen", 256'(gen_count), 256'd0);
      check_eq("rst_mid_step", 256'(eng_step), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_board = block;
      #1;
      check_eq("rst_rel_ready", 256'(cmd_ready), 256'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_rel_load", eng_q, block);

      check_eq("step_load_exclusive", 256'(excl_viol), 256'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
